stream_argmax: RTL

- Classification stage directly downstream of the top-level dataflow network's final FC layer.
- Consumes the streamed signed fixed-point logit vector (default 10 logits, 8-bit, one per beat) and emits one result per vector: winning class index and its value.
- Turns raw network output into a single handshaked label for the host side.

---
 rtl/stream_argmax_pkg.sv | 31 +++
 rtl/stream_argmax_lane_reduce.sv | 45 ++++
 rtl/stream_argmax.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/stream_argmax_pkg.sv
// Shared types and helpers for the stream_argmax classification stage.
// Optional margin output is enabled with macro STREAM_ARGMAX_MARGIN_EN.
package stream_argmax_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Comparisons are done on sign-extended values so one helper serves any logit width.
  localparam int CMP_W = 32;

  function automatic logic sgt(input logic signed [CMP_W-1:0] a,
                               input logic signed [CMP_W-1:0] b);
    return a > b;
  endfunction

  function automatic logic signed [CMP_W-1:0] smax(input logic signed [CMP_W-1:0] a,
                                                  input logic signed [CMP_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic int beats_per_vec(input int size, input int par);
    return size / par;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_argmax_lane_reduce.sv
// Combinational reduction of one input beat to its max value and lane (lowest lane on ties).
// With STREAM_ARGMAX_MARGIN_EN it also produces the beat runner-up.
module stream_argmax_lane_reduce
  import stream_argmax_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int LANE_W = 1
) (
  input  logic signed [DATA_W-1:0] lanes [LANES],
  output logic signed [DATA_W-1:0] beat_max,
  output logic        [LANE_W-1:0] beat_lane
`ifdef STREAM_ARGMAX_MARGIN_EN
  ,
  output logic signed [DATA_W-1:0] beat_second
`endif
);

`ifdef STREAM_ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    beat_max  = lanes[0];
    beat_lane = '0;
`ifdef STREAM_ARGMAX_MARGIN_EN
    beat_second = MIN_VAL;
`endif
    for (int l = 1; l < LANES; l++) begin
      if (sgt(CMP_W'(lanes[l]), CMP_W'(beat_max))) begin
`ifdef STREAM_ARGMAX_MARGIN_EN
        beat_second = beat_max;
`endif
        beat_max  = lanes[l];
        beat_lane = LANE_W'(l);
      end
`ifdef STREAM_ARGMAX_MARGIN_EN
      else begin
        beat_second = DATA_W'(smax(CMP_W'(beat_second), CMP_W'(lanes[l])));
      end
`endif
    end
  end

endmodule

// File: rtl/stream_argmax.sv
// Streaming argmax over a signed logit vector: one handshaked (index, max) result per vector.
// Define STREAM_ARGMAX_MARGIN_EN to add data_out_0_margin (max minus runner-up).
module stream_argmax
  import stream_argmax_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int INDEX_WIDTH                 = clog2_min1(DATA_IN_0_TENSOR_SIZE_DIM_0)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic signed [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
  input  logic                                    data_in_0_valid,
  output logic                                    data_in_0_ready,
  output logic        [INDEX_WIDTH-1:0]           data_out_0,
  output logic signed [DATA_IN_0_PRECISION_0-1:0] data_out_0_max,
  output logic                                    data_out_0_valid,
  input  logic                                    data_out_0_ready
`ifdef STREAM_ARGMAX_MARGIN_EN
  ,
  output logic        [DATA_IN_0_PRECISION_0:0]   data_out_0_margin
`endif
);

  localparam int W      = DATA_IN_0_PRECISION_0;
  localparam int PAR    = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int B      = beats_per_vec(DATA_IN_0_TENSOR_SIZE_DIM_0, PAR);
  localparam int CNT_W  = clog2_min1(B);
  localparam int LANE_W = clog2_min1(PAR);

  if ((DATA_IN_0_TENSOR_SIZE_DIM_0 % PAR) != 0 ||
      DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_cfg
    $error("stream_argmax: invalid parameter combination");
  end

  state_t                   state;
  logic [CNT_W-1:0]         beat_cnt;
  logic signed [W-1:0]      run_max;
  logic [INDEX_WIDTH-1:0]   run_idx;

  logic signed [W-1:0]      beat_max;
  logic [LANE_W-1:0]        beat_lane;
  logic [INDEX_WIDTH-1:0]   beat_idx;
  logic signed [W-1:0]      nxt_max;
  logic [INDEX_WIDTH-1:0]   nxt_idx;
  logic                     accept;
  logic                     first_beat;
  logic                     last_beat;
  logic                     beat_wins;

  logic                     vld_p1;
  logic [INDEX_WIDTH-1:0]   idx_p1;
  logic signed [W-1:0]      max_p1;

`ifdef STREAM_ARGMAX_MARGIN_EN
  logic signed [W-1:0]      beat_second;
  logic signed [W-1:0]      run_second;
  logic signed [W-1:0]      nxt_second;
  logic [W:0]               margin_p1;
`endif

  stream_argmax_lane_reduce #(
    .DATA_W (W),
    .LANES  (PAR),
    .LANE_W (LANE_W)
  ) u_lane_reduce (
    .lanes       (data_in_0),
    .beat_max    (beat_max),
    .beat_lane   (beat_lane)
`ifdef STREAM_ARGMAX_MARGIN_EN
    ,
    .beat_second (beat_second)
`endif
  );

  // In HOLD a new beat can only enter when the held result leaves in the same cycle.
  assign data_in_0_ready = (state == ACCUM) || data_out_0_ready;
  assign accept          = data_in_0_valid && data_in_0_ready;
  assign first_beat      = (beat_cnt == '0);
  assign last_beat       = (beat_cnt == CNT_W'(B - 1));
  assign beat_idx        = INDEX_WIDTH'(int'(beat_cnt) * PAR + int'(beat_lane));
  assign beat_wins       = sgt(CMP_W'(beat_max), CMP_W'(run_max));

  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    if (first_beat || beat_wins) begin
      nxt_max = beat_max;
      nxt_idx = beat_idx;
    end
  end

`ifdef STREAM_ARGMAX_MARGIN_EN
  always_comb begin
    nxt_second = run_second;
    if (first_beat) begin
      nxt_second = beat_second;
    end else if (beat_wins) begin
      nxt_second = W'(smax(CMP_W'(run_max), CMP_W'(beat_second)));
    end else begin
      nxt_second = W'(smax(CMP_W'(run_second), CMP_W'(beat_max)));
    end
  end
`endif

  // Stage p1: result register, loaded on the edge that accepts the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      beat_cnt <= '0;
      run_max  <= '0;
      run_idx  <= '0;
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      max_p1   <= '0;
`ifdef STREAM_ARGMAX_MARGIN_EN
      run_second <= '0;
      margin_p1  <= '0;
`endif
    end else begin
      if (accept) begin
        run_max  <= nxt_max;
        run_idx  <= nxt_idx;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
`ifdef STREAM_ARGMAX_MARGIN_EN
        run_second <= nxt_second;
`endif
      end
      if (accept && last_beat) begin
        state  <= HOLD;
        vld_p1 <= 1'b1;
        idx_p1 <= nxt_idx;
        max_p1 <= nxt_max;
`ifdef STREAM_ARGMAX_MARGIN_EN
        margin_p1 <= (W+1)'(nxt_max) - (W+1)'(nxt_second);
`endif
      end else if (state == HOLD && data_out_0_ready) begin
        state  <= ACCUM;
        vld_p1 <= 1'b0;
      end
    end
  end

  assign data_out_0_valid = vld_p1;
  assign data_out_0       = idx_p1;
  assign data_out_0_max   = max_p1;
`ifdef STREAM_ARGMAX_MARGIN_EN
  assign data_out_0_margin = margin_p1;
`endif

endmodule
